// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared definitions for the 6502 / DMA bus arbiter: FSM state encodings and the bus beat
// bundle that the arbiter steers onto the memory bus.
package cpu_bus_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE      = 2'd0;
  localparam logic [1:0] ARB_HALT_PEND = 2'd1;
  localparam logic [1:0] ARB_DMA       = 2'd2;
  localparam logic [1:0] ARB_HANDBACK  = 2'd3;

  typedef struct packed {
    logic [15:0] addr;
    logic        write;
    logic [7:0]  wdata;
  } bus_beat_t;

  function automatic bus_beat_t bus_select(input logic      sel_dma,
                                           input bus_beat_t cpu_b,
                                           input bus_beat_t dma_b);
    bus_beat_t r;
    if (sel_dma) begin
      r = dma_b;
    end else begin
      r = cpu_b;
    end
    return r;
  endfunction

endpackage

// File: rtl/cpu_bus_arbiter_burst_counter.sv
// Loadable saturating counter with terminal flag; counts up (burst length) or down (cooldown).
module arb_burst_counter #(
  parameter int             W    = 4,
  parameter bit             DOWN = 1'b0,
  parameter logic [W-1:0]   TERM = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         term_o
);

  logic [W-1:0] count_q, count_d;

  // Next count: load wins, otherwise step toward TERM and hold there.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != TERM)) begin
      if (DOWN) begin
        count_d = count_q - W'(1);
      end else begin
        count_d = count_q + W'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign term_o = (count_q == TERM);

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Shares the memory bus between the 6502 core and one DMA requester. The core is halted via
// 'ready' and the bus is only handed over once the core sits on a read cycle.
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 64,
  parameter int COOLDOWN  = 4,
  parameter int WR_LIMIT  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_address,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_data_o,
  output logic        cpu_ready,
  input  logic        dma_req,
  output logic        dma_gnt,
  input  logic [15:0] dma_address,
  input  logic        dma_write,
  input  logic [7:0]  dma_data_o,
  output logic [15:0] mem_address,
  output logic        mem_write,
  output logic [7:0]  mem_wdata,
  output logic        dbg_wr_overrun
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int CW = $clog2(COOLDOWN + 1);
  localparam int WW = $clog2(WR_LIMIT + 2);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [CW-1:0] COOL_LOAD  = CW'(COOLDOWN);
  localparam logic [WW-1:0] WR_SAT     = WW'(WR_LIMIT + 1);
  localparam logic [WW-1:0] WR_LIM     = WW'(WR_LIMIT);

  logic [1:0]    state_q, state_d;
  logic          ready_q, ready_d;
  logic          gnt_q, gnt_d;
  logic          ovr_q, ovr_d;
  logic [WW-1:0] wr_cnt_q, wr_cnt_d;
  logic          burst_load_s, burst_term_s;
  logic          cool_load_s, cool_zero_s;
  bus_beat_t     cpu_beat_s, dma_beat_s, mem_beat_s;

  arb_burst_counter #(.W(BW), .DOWN(1'b0), .TERM(BURST_LAST)) u_burst (
    .clk(clk), .reset(reset), .load_i(burst_load_s), .load_val_i({BW{1'b0}}),
    .en_i(state_q == ARB_DMA), .term_o(burst_term_s)
  );

  arb_burst_counter #(.W(CW), .DOWN(1'b1), .TERM({CW{1'b0}})) u_cool (
    .clk(clk), .reset(reset), .load_i(cool_load_s), .load_val_i(COOL_LOAD),
    .en_i(state_q == ARB_IDLE), .term_o(cool_zero_s)
  );

  // Arbitration FSM next-state logic.
  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    gnt_d        = gnt_q;
    ovr_d        = ovr_q;
    wr_cnt_d     = wr_cnt_q;
    burst_load_s = 1'b0;
    cool_load_s  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        ready_d  = 1'b1;
        gnt_d    = 1'b0;
        wr_cnt_d = '0;
        if (dma_req && cool_zero_s) begin
          state_d = ARB_HALT_PEND;
          ready_d = 1'b0;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_HALT_PEND: begin
        ready_d = 1'b0;
        gnt_d   = 1'b0;
        if (!dma_req) begin
          state_d  = ARB_IDLE;
          ready_d  = 1'b1;
          wr_cnt_d = '0;
        end else if (cpu_write) begin
          // Core ignores ready while writing, so wait it out and watch for runaway pushes.
          wr_cnt_d = (wr_cnt_q == WR_SAT) ? wr_cnt_q : wr_cnt_q + WW'(1);
          if (wr_cnt_q >= WR_LIM) begin
            ovr_d = 1'b1;
          end else begin
            ovr_d = ovr_q;
          end
        end else begin
          state_d      = ARB_DMA;
          gnt_d        = 1'b1;
          burst_load_s = 1'b1;
          wr_cnt_d     = '0;
        end
      end
      ARB_DMA: begin
        ready_d = 1'b0;
        gnt_d   = 1'b1;
        if (burst_term_s) begin
          state_d     = ARB_HANDBACK;
          gnt_d       = 1'b0;
          cool_load_s = 1'b1;
        end else if (!dma_req) begin
          state_d = ARB_HANDBACK;
          gnt_d   = 1'b0;
        end else begin
          state_d = ARB_DMA;
        end
      end
      ARB_HANDBACK: begin
        state_d = ARB_IDLE;
        ready_d = 1'b1;
        gnt_d   = 1'b0;
      end
      default: begin
        state_d = ARB_IDLE;
        ready_d = 1'b1;
        gnt_d   = 1'b0;
      end
    endcase
  end

  // FSM and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      ready_q  <= 1'b1;
      gnt_q    <= 1'b0;
      ovr_q    <= 1'b0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      gnt_q    <= gnt_d;
      ovr_q    <= ovr_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign cpu_beat_s = '{addr: cpu_address, write: cpu_write, wdata: cpu_data_o};
  assign dma_beat_s = '{addr: dma_address, write: dma_write, wdata: dma_data_o};
  assign mem_beat_s = bus_select(gnt_q, cpu_beat_s, dma_beat_s);

  assign mem_address    = mem_beat_s.addr;
  assign mem_write      = mem_beat_s.write;
  assign mem_wdata      = mem_beat_s.wdata;
  assign cpu_ready      = ready_q;
  assign dma_gnt        = gnt_q;
  assign dbg_wr_overrun = ovr_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter with MAX_BURST=4, COOLDOWN=4, WR_LIMIT=3.
module tb_cpu_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_address;
  logic        cpu_write;
  logic [7:0]  cpu_data_o;
  logic        cpu_ready;
  logic        dma_req;
  logic        dma_gnt;
  logic [15:0] dma_address;
  logic        dma_write;
  logic [7:0]  dma_data_o;
  logic [15:0] mem_address;
  logic        mem_write;
  logic [7:0]  mem_wdata;
  logic        dbg_wr_overrun;

  int checks = 0;
  int errors = 0;

  cpu_bus_arbiter #(.MAX_BURST(4), .COOLDOWN(4), .WR_LIMIT(3)) dut (
    .clk(clk), .reset(reset),
    .cpu_address(cpu_address), .cpu_write(cpu_write), .cpu_data_o(cpu_data_o),
    .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_gnt(dma_gnt),
    .dma_address(dma_address), .dma_write(dma_write), .dma_data_o(dma_data_o),
    .mem_address(mem_address), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .dbg_wr_overrun(dbg_wr_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; cpu_address = 16'h1000; cpu_write = 1'b0; cpu_data_o = 8'h00;
    dma_req = 1'b0; dma_address = 16'h8000; dma_write = 1'b0; dma_data_o = 8'h00;
    #1;
    check("rst_ready", 32'(cpu_ready), 32'd1);
    check("rst_gnt", 32'(dma_gnt), 32'd0);
    check("rst_ovr", 32'(dbg_wr_overrun), 32'd0);
    check("rst_addr", 32'(mem_address), 32'h1000);
    step();
    step();
    reset = 1'b0;

    // Test 1: core on a read loop, dma_req rises in cycle T
    step();
    cpu_address = 16'h2000; dma_req = 1'b1; #1;
    check("t1_T_ready", 32'(cpu_ready), 32'd1);
    step();
    check("t1_T1_ready", 32'(cpu_ready), 32'd0);
    check("t1_T1_gnt", 32'(dma_gnt), 32'd0);
    check("t1_T1_addr", 32'(mem_address), 32'h2000);
    step();
    dma_write = 1'b1; dma_data_o = 8'h5A; #1;
    check("t1_T2_gnt", 32'(dma_gnt), 32'd1);
    check("t1_T2_addr", 32'(mem_address), 32'h8000);
    check("t1_T2_wr", 32'(mem_write), 32'd1);
    check("t1_T2_wdata", 32'(mem_wdata), 32'h5A);
    step();
    dma_write = 1'b0;
    check("t1_T3_gnt", 32'(dma_gnt), 32'd1);
    step();
    dma_req = 1'b0; #1;
    check("t1_T4_gnt", 32'(dma_gnt), 32'd1);
    step();
    check("t1_hb_gnt", 32'(dma_gnt), 32'd0);
    check("t1_hb_ready", 32'(cpu_ready), 32'd0);
    check("t1_hb_addr", 32'(mem_address), 32'h2000);
    step();
    check("t1_idle_ready", 32'(cpu_ready), 32'd1);

    // Test 2: request during BRK, three pushes in HALT_PEND
    cpu_address = 16'hC000; dma_req = 1'b1; #1;
    step();
    check("t2_halt_ready", 32'(cpu_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cpu_write = 1'b1; cpu_address = 16'h01FD - 16'(i); cpu_data_o = 8'hA0 + 8'(i); #1;
      check("t2_push_gnt", 32'(dma_gnt), 32'd0);
      check("t2_push_wr", 32'(mem_write), 32'd1);
      check("t2_push_addr", 32'(mem_address), 32'(16'h01FD - 16'(i)));
      check("t2_push_data", 32'(mem_wdata), 32'(8'hA0 + 8'(i)));
      step();
    end
    cpu_write = 1'b0; cpu_address = 16'hFFFE; #1;
    check("t2_read_gnt", 32'(dma_gnt), 32'd0);
    step();
    check("t2_dma_gnt", 32'(dma_gnt), 32'd1);
    check("t2_ovr", 32'(dbg_wr_overrun), 32'd0);
    dma_req = 1'b0;
    step();
    check("t2_hb_addr", 32'(mem_address), 32'hFFFE);
    step();
    check("t2_idle_ready", 32'(cpu_ready), 32'd1);

    // Test 3: dma_req held, burst limit 4, cooldown 4
    dma_req = 1'b1; cpu_address = 16'h3000;
    step();
    check("t3_halt_ready", 32'(cpu_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_burst_gnt", 32'(dma_gnt), 32'd1);
    end
    step();
    check("t3_hb_gnt", 32'(dma_gnt), 32'd0);
    check("t3_hb_ready", 32'(cpu_ready), 32'd0);
    // four IDLE cycles counting cooldown down, then the IDLE cycle that re-arbitrates
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_cool_ready", 32'(cpu_ready), 32'd1);
      check("t3_cool_gnt", 32'(dma_gnt), 32'd0);
    end
    step();
    check("t3_rehalt_ready", 32'(cpu_ready), 32'd0);
    check("t3_rehalt_gnt", 32'(dma_gnt), 32'd0);
    dma_req = 1'b0;
    step();
    check("t3_release_ready", 32'(cpu_ready), 32'd1);

    // Test 4: one-cycle dma_req pulse while the core writes
    cpu_write = 1'b1; cpu_address = 16'h01F0; dma_req = 1'b1;
    step();
    check("t4_halt_ready", 32'(cpu_ready), 32'd0);
    dma_req = 1'b0;
    step();
    check("t4_idle_ready", 32'(cpu_ready), 32'd1);
    check("t4_idle_gnt", 32'(dma_gnt), 32'd0);
    cpu_write = 1'b0;
    step();
    check("t4_gnt_stays", 32'(dma_gnt), 32'd0);

    // Test 6: four consecutive writes in HALT_PEND set the sticky overrun flag
    dma_req = 1'b1; cpu_address = 16'h4000;
    step();
    cpu_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
    end
    check("t6_ovr_after3", 32'(dbg_wr_overrun), 32'd0);
    step();
    check("t6_ovr_after4", 32'(dbg_wr_overrun), 32'd1);
    cpu_write = 1'b0; cpu_address = 16'h4010;
    step();
    check("t6_dma_gnt", 32'(dma_gnt), 32'd1);
    check("t6_ovr_sticky", 32'(dbg_wr_overrun), 32'd1);

    // Test 5: async reset while DMA owns the bus
    dma_address = 16'h9999;
    reset = 1'b1; #1;
    check("t5_gnt", 32'(dma_gnt), 32'd0);
    check("t5_ready", 32'(cpu_ready), 32'd1);
    check("t5_addr", 32'(mem_address), 32'h4010);
    check("t5_ovr_cleared", 32'(dbg_wr_overrun), 32'd0);
    dma_req = 1'b0;
    step();
    reset = 1'b0;
    step();
    cpu_address = 16'h5000; cpu_write = 1'b1; cpu_data_o = 8'h77; #1;
    check("t5_run_ready", 32'(cpu_ready), 32'd1);
    check("t5_run_addr", 32'(mem_address), 32'h5000);
    check("t5_run_wr", 32'(mem_write), 32'd1);
    check("t5_run_data", 32'(mem_wdata), 32'h77);
    step();
    check("t5_run_gnt", 32'(dma_gnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
